// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt controller: maskable channels with lowest-index priority,
// plus one non-maskable line that can preempt a single level of IRQ service.
module interrupt_controller #(
  parameter int unsigned N_IRQ      = 8,
  parameter int unsigned VEC_W      = 32,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0200,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
  parameter logic [31:0] NMI_VEC    = 32'h0000_0180
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             nmi_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             int_ack,
  input  logic             int_done,
  output logic             int_req,
  output logic             int_nmi,
  output logic [3:0]       int_id,
  output logic [VEC_W-1:0] int_vec,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending_q,
  output logic [N_IRQ-1:0] mask_q
);

  typedef enum logic [2:0] {StIdle, StReq, StSvc, StNmiReq, StNmiSvc} state_e;

  state_e             state_q, state_d;
  logic [N_IRQ-1:0]   irq_prev_q;
  logic               nmi_prev_q;
  logic               nmi_pend_q;
  logic [3:0]         int_id_q, int_id_d;
  logic               int_nmi_q, int_nmi_d;
  logic [VEC_W-1:0]   int_vec_q, int_vec_d;
  logic [3:0]         saved_id_q, saved_id_d;
  logic               preempt_q, preempt_d;
  logic [N_IRQ-1:0]   eligible;
  logic [N_IRQ-1:0]   id_onehot;
  logic [N_IRQ-1:0]   irq_clr;
  logic               nmi_clr;
  logic [3:0]         low_id;

  function automatic logic [VEC_W-1:0] chan_vec(logic [3:0] id);
    logic [VEC_W-1:0] base, stride, idx;
    base   = VEC_W'(VEC_BASE);
    stride = VEC_W'(VEC_STRIDE);
    idx    = VEC_W'(id);
    return base + stride * idx;
  endfunction

  assign eligible = pending_q & ~mask_q;

  // Downward scan so the lowest eligible index is the one left standing.
  always_comb begin
    low_id = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (eligible[k]) low_id = 4'(k);
    end
  end

  always_comb begin
    id_onehot = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      id_onehot[k] = (int_id_q == 4'(k));
    end
  end

  always_comb begin
    state_d    = state_q;
    int_id_d   = int_id_q;
    int_nmi_d  = int_nmi_q;
    int_vec_d  = int_vec_q;
    saved_id_d = saved_id_q;
    preempt_d  = preempt_q;
    irq_clr    = '0;
    nmi_clr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (nmi_pend_q) begin
          state_d   = StNmiReq;
          int_nmi_d = 1'b1;
          int_id_d  = '0;
          int_vec_d = VEC_W'(NMI_VEC);
          preempt_d = 1'b0;
        end else if (|eligible) begin
          state_d   = StReq;
          int_nmi_d = 1'b0;
          int_id_d  = low_id;
          int_vec_d = chan_vec(low_id);
        end
      end
      StReq: begin
        if (int_ack) begin
          state_d = StSvc;
          irq_clr = id_onehot;
        end
      end
      StSvc: begin
        // End-of-service beats a coinciding NMI; the NMI is then taken from idle.
        if (int_done) begin
          state_d = StIdle;
        end else if (nmi_pend_q) begin
          state_d    = StNmiReq;
          saved_id_d = int_id_q;
          preempt_d  = 1'b1;
          int_nmi_d  = 1'b1;
          int_id_d   = '0;
          int_vec_d  = VEC_W'(NMI_VEC);
        end
      end
      StNmiReq: begin
        if (int_ack) begin
          state_d = StNmiSvc;
          nmi_clr = 1'b1;
        end
      end
      StNmiSvc: begin
        if (int_done) begin
          if (preempt_q) begin
            state_d   = StSvc;
            int_id_d  = saved_id_q;
            int_nmi_d = 1'b0;
            int_vec_d = chan_vec(saved_id_q);
            preempt_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      irq_prev_q <= '0;
      nmi_prev_q <= 1'b0;
      pending_q  <= '0;
      nmi_pend_q <= 1'b0;
      mask_q     <= '1;
      int_id_q   <= '0;
      int_nmi_q  <= 1'b0;
      int_vec_q  <= '0;
      saved_id_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_in;
      nmi_prev_q <= nmi_in;
      // A fresh edge on the acknowledged line wins over the clear.
      pending_q  <= (pending_q & ~irq_clr) | (irq_in & ~irq_prev_q);
      nmi_pend_q <= (nmi_pend_q & ~nmi_clr) | (nmi_in & ~nmi_prev_q);
      if (mask_we) mask_q <= mask_wdata;
      int_id_q   <= int_id_d;
      int_nmi_q  <= int_nmi_d;
      int_vec_q  <= int_vec_d;
      saved_id_q <= saved_id_d;
      preempt_q  <= preempt_d;
    end
  end

  assign int_req    = (state_q == StReq) || (state_q == StNmiReq);
  assign in_service = (state_q == StSvc) || (state_q == StNmiSvc) ||
                      ((state_q == StNmiReq) && preempt_q);
  assign int_id     = int_id_q;
  assign int_nmi    = int_nmi_q;
  assign int_vec    = int_vec_q;

endmodule
